// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants, reused by the fetch queue, the decode
// stage and the pipeline registers.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  add4;
    } fetch_pair_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Register array for the fetch queue: DEPTH entries of {instr, add4}.
// It has one synchronous write port and one asynchronous read port. The entries are not reset.
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fetch_pair_t   wdata,
    input  logic [AW-1:0] raddr,
    output fetch_pair_t   rdata
);

    fetch_pair_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction FIFO between fetch and decode, with a flush on pipeline redirect.
// Optional empty-queue forwarding path, enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [INSTR_W-1:0]      in_instr,
    input  logic [ADDR_W-1:0]       in_add4,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [INSTR_W-1:0]      out_instr,
    output logic [ADDR_W-1:0]       out_add4,
    input  logic                    out_ready,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    fetch_pair_t   head;
    fetch_pair_t   in_pair;
    logic          bypass;
    logic          push;
    logic          write;
    logic          pop;
    logic          pop_q;

    assign in_pair = {in_instr, in_add4};

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = (cnt == '0) && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    // in_ready depends on stored state only, so fetch never sees a path from decode's stall.
    assign in_ready  = (cnt != CNT_FULL);
    assign out_valid = !flush && ((cnt != '0) || bypass);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign write     = push && !(bypass && out_ready);
    assign pop_q     = pop && !bypass;

    assign out_instr = !out_valid ? NOP_INSTR : (bypass ? in_instr : head.instr);
    assign out_add4  = !out_valid ? '0        : (bypass ? in_add4  : head.add4);
    assign count     = cnt;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (write),
        .waddr (wp),
        .wdata (in_pair),
        .raddr (rp),
        .rdata (head)
    );

    // A flush drops everything behind wp, but it keeps a same-cycle push: that push is the delay slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (write) begin
                wp <= wp + PTR_ONE;
            end
            if (flush) begin
                rp  <= wp;
                cnt <= write ? CNT_ONE : '0;
            end else begin
                if (pop_q) begin
                    rp <= rp + PTR_ONE;
                end
                case ({write, pop_q})
                    2'b10:   cnt <= cnt + CNT_ONE;
                    2'b01:   cnt <= cnt - CNT_ONE;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand sequences,
// and a randomized run against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [31:0]   in_instr;
    logic [31:0]   in_add4;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [31:0]   out_add4;
    logic          out_ready;
    logic          flush;
    logic [AW:0]   count;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        rst;
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] instr;
        logic [31:0] add4;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_add4;
        int          exp_count;
        logic        exp_ready;
    } vec_t;

    vec_t tbl[$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_add4   (in_add4),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_add4  (out_add4),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic iv, logic ordy, logic fl, logic [31:0] add4,
                                logic ev, logic [31:0] eadd4, int ecnt, logic erdy);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ordy = ordy; v.fl = fl;
        v.instr = 32'h1000_0000 | add4;
        v.add4 = add4;
        v.exp_valid = ev;
        v.exp_instr = ev ? (32'h1000_0000 | eadd4) : 32'h0;
        v.exp_add4 = ev ? eadd4 : 32'h0;
        v.exp_count = ecnt;
        v.exp_ready = erdy;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic setIdle();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_instr = 32'h0; in_add4 = 32'h0;
    endtask

    // One cycle: drive at negedge, clock, then idle the inputs and check the registered view
    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        reset = v.rst; in_valid = v.iv; out_ready = v.ordy; flush = v.fl;
        in_instr = v.instr; in_add4 = v.add4;
        @(posedge clk);
        #1 setIdle();
        #1;
        checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(v.exp_valid));
        checkOutput({tag, ".out_instr"}, 64'(out_instr), 64'(v.exp_instr));
        checkOutput({tag, ".out_add4"},  64'(out_add4),  64'(v.exp_add4));
        checkOutput({tag, ".count"},     64'(count),     64'(v.exp_count));
        checkOutput({tag, ".in_ready"},  64'(in_ready),  64'(v.exp_ready));
    endtask

    initial begin
        logic [63:0] model[$];
        logic        bypass_on;
        logic        m_rdy, m_byp, m_valid, m_push, m_pop;
        logic [63:0] m_head;

`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_on = 1'b1;
`else
        bypass_on = 1'b0;
`endif
        setIdle();
        reset = 1'b1;

        // reset, first push, fill, overflow attempt, drain
        tbl.push_back(mk(1,0,0,0, 32'h0,    0, 32'h0,    0, 1));
        tbl.push_back(mk(0,1,0,0, 32'h3004, 1, 32'h3004, 1, 1));
        tbl[1].instr = 32'h3C01_0001;
        tbl[1].exp_instr = 32'h3C01_0001;
        tbl.push_back(mk(0,1,0,0, 32'h3008, 1, 32'h3004, 2, 1));
        tbl.push_back(mk(0,1,0,0, 32'h300C, 1, 32'h3004, 3, 1));
        tbl.push_back(mk(0,1,0,0, 32'h3010, 1, 32'h3004, 4, 0));
        tbl.push_back(mk(0,1,0,0, 32'h3014, 1, 32'h3004, 4, 0));
        for (int i = 2; i <= 5; i++) begin
            tbl[i].exp_instr = 32'h3C01_0001;
        end
        tbl.push_back(mk(0,0,1,0, 32'h0,    1, 32'h3008, 3, 1));
        tbl.push_back(mk(0,0,1,0, 32'h0,    1, 32'h300C, 2, 1));
        tbl.push_back(mk(0,0,1,0, 32'h0,    1, 32'h3010, 1, 1));
        tbl.push_back(mk(0,0,1,0, 32'h0,    0, 32'h0,    0, 1));
        // flush with delay-slot push
        tbl.push_back(mk(0,1,0,0, 32'h3040, 1, 32'h3040, 1, 1));
        tbl.push_back(mk(0,1,0,0, 32'h3044, 1, 32'h3040, 2, 1));
        tbl.push_back(mk(0,1,0,0, 32'h3048, 1, 32'h3040, 3, 1));
        tbl.push_back(mk(0,1,1,1, 32'h3020, 1, 32'h3020, 1, 1));
        tbl.push_back(mk(0,0,1,0, 32'h0,    0, 32'h0,    0, 1));
        // reset mid-operation, with a push that reset must override
        tbl.push_back(mk(0,1,0,0, 32'h3050, 1, 32'h3050, 1, 1));
        tbl.push_back(mk(0,1,0,0, 32'h3054, 1, 32'h3050, 2, 1));
        tbl.push_back(mk(0,1,0,0, 32'h3058, 1, 32'h3050, 3, 1));
        tbl.push_back(mk(1,1,1,0, 32'h305C, 0, 32'h0,    0, 1));
        // full + pop in the same cycle, then flush while full blocks the push
        tbl.push_back(mk(0,1,0,0, 32'h3060, 1, 32'h3060, 1, 1));
        tbl.push_back(mk(0,1,0,0, 32'h3064, 1, 32'h3060, 2, 1));
        tbl.push_back(mk(0,1,0,0, 32'h3068, 1, 32'h3060, 3, 1));
        tbl.push_back(mk(0,1,0,0, 32'h306C, 1, 32'h3060, 4, 0));
        tbl.push_back(mk(0,1,1,0, 32'h3070, 1, 32'h3064, 3, 1));
        tbl.push_back(mk(0,1,0,0, 32'h3074, 1, 32'h3064, 4, 0));
        tbl.push_back(mk(0,1,1,1, 32'h3078, 0, 32'h0,    0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i], $sformatf("tbl%0d", i));
        end

        // pointer wrap: steady push+pop at occupancy 2
        applyStimulus(mk(0,1,0,0, 32'h3100, 1, 32'h3100, 1, 1), "wrap_fill0");
        applyStimulus(mk(0,1,0,0, 32'h3104, 1, 32'h3100, 2, 1), "wrap_fill1");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(mk(0,1,1,0, 32'h3108 + 32'(4*i), 1, 32'h3104 + 32'(4*i), 2, 1),
                          $sformatf("wrap%0d", i));
        end
        applyStimulus(mk(1,0,0,0, 32'h0, 0, 32'h0, 0, 1), "wrap_reset");

        // empty-queue push with decode ready: same-cycle view depends on the build
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h2402_0005; in_add4 = 32'h3200;
        #1;
        checkOutput("byp.out_valid", 64'(out_valid), 64'(bypass_on));
        checkOutput("byp.out_instr", 64'(out_instr), bypass_on ? 64'h2402_0005 : 64'h0);
        @(posedge clk);
        #1 setIdle();
        #1;
        checkOutput("byp.count", 64'(count), bypass_on ? 64'd0 : 64'd1);
        applyStimulus(mk(1,0,0,0, 32'h0, 0, 32'h0, 0, 1), "byp_reset");

        // randomized run against a queue model
        model.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            reset     = ($urandom_range(63) == 0);
            flush     = ($urandom_range(15) == 0);
            in_valid  = ($urandom_range(9) < 6);
            out_ready = ($urandom_range(1) == 1);
            in_instr  = $urandom;
            in_add4   = $urandom;

            m_rdy   = (model.size() < DEPTH);
            m_byp   = bypass_on && (model.size() == 0) && in_valid && !flush;
            m_valid = !flush && ((model.size() > 0) || m_byp);
            m_head  = m_byp ? {in_instr, in_add4} : ((model.size() > 0) ? model[0] : 64'h0);
            if (!m_valid) m_head = 64'h0;
            #1;
            checkOutput("rnd.in_ready",  64'(in_ready),  64'(m_rdy));
            checkOutput("rnd.out_valid", 64'(out_valid), 64'(m_valid));
            checkOutput("rnd.head",      {out_instr, out_add4}, m_head);
            checkOutput("rnd.count",     64'(count),     64'(model.size()));

            @(posedge clk);
            m_push = in_valid && m_rdy;
            m_pop  = m_valid && out_ready;
            if (reset) begin
                model.delete();
            end else if (flush) begin
                model.delete();
                if (m_push) model.push_back({in_instr, in_add4});
            end else begin
                if (m_pop && !m_byp) void'(model.pop_front());
                if (m_push && !(m_byp && out_ready)) model.push_back({in_instr, in_add4});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small instruction FIFO placed directly downstream of the fetch unit and upstream of the decode stage.
- Stores {instruction, PC+4} pairs produced by fetch.
- Decouples decode stalls from fetch: fetch receives a registered-path "ready" in place of a raw stall.
- Drops wrong-path entries when the pipeline redirects.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
AW, $clog2(DEPTH), pointer width (derived; not overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  fetch presents a valid pair this cycle
in_instr  input  32  fetched instruction word
in_add4  input  32  PC+4 of the fetched instruction
in_ready  output  1  queue can accept a pair; fetch holds its PC when low
out_valid  output  1  head entry valid for decode
out_instr  output  32  head instruction; 32'h0000_0000 (nop) when out_valid=0
out_add4  output  32  head PC+4; 0 when out_valid=0
out_ready  input  1  decode consumes head this cycle
flush  input  1  discard queued entries (branch/jump redirect)
count  output  AW+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH x 64-bit array. Write pointer wp and read pointer rp are AW bits wide and wrap modulo DEPTH. Occupancy cnt is AW+1 bits.
- Reset: wp=0, rp=0, cnt=0. Storage contents are don't-care. Outputs after the reset edge: out_valid=0, out_instr=0, out_add4=0, count=0, in_ready=1.
- in_ready = (cnt != DEPTH). It depends only on state, with no combinational path from out_ready.
- Push: occurs when in_valid && in_ready. Writes mem[wp] and increments wp.
- Pop: occurs when out_valid && out_ready. Increments rp.
- Normal output: out_valid = (cnt != 0). The head is driven combinationally from mem[rp].
- Latency: a pushed pair is visible at the output the cycle after the push (1 cycle).
- cnt update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Full (cnt==DEPTH): in_ready=0 and in_valid is ignored. A pop in the same cycle does not open the slot until the next cycle.
- Empty (cnt==0): out_valid=0. out_ready is ignored.
- flush=1 takes priority over pop:
  - Sets rp <= wp and drops all stored entries.
  - Forces out_valid=0 in the flush cycle, so no pop occurs.
  - A push in the same cycle is still written: it is the delay-slot instruction and is kept. cnt becomes 1 if a push occurred, otherwise 0.
  - A push while full during flush is still blocked, because in_ready uses the pre-flush cnt.
- Reset has priority over flush, push and pop. Reset during any occupancy returns the block to the empty state in one cycle.
- Pointer wrap: when wp or rp reaches DEPTH-1, it returns to 0 on the next increment. The full/empty decision uses cnt only, never pointer equality.

Optional Feature:
Macro FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When cnt==0, in_valid=1 and flush=0, the input is forwarded combinationally: out_valid=1, out_instr=in_instr, out_add4=in_add4.
  - If out_ready=1 in that cycle, the pair is consumed and not written, so cnt stays 0.
  - If out_ready=0, the pair is written normally.
  - Empty-queue latency is 0 cycles.
- Undefined: no forwarding path. Latency is always 1 cycle.

Decomposition:
- Shared package fetch_pkg:
  - INSTR_W=32, ADDR_W=32.
  - NOP_INSTR=32'h0000_0000.
  - Typedef fetch_pair_t = {instr, add4}.
  - Reused by the decode stage and the pipeline registers.
- One natural sub-module: fetch_queue_mem. It is the DEPTH x 64 register array with a synchronous write port and an asynchronous read port. Pointers, count and control stay in fetch_queue.

Test Plan:
1. Reset: after reset, push 32'h3C01_0001 / add4 32'h3004 with out_ready=0. Next cycle: out_valid=1, out_instr=32'h3C01_0001, out_add4=32'h3004, count=1.
2. Fill: with out_ready=0, push 4 pairs (add4 0x3004..0x3010). Then count=4 and in_ready=0. A 5th push with in_valid=1 is ignored. Pops then return add4 0x3004, 0x3008, 0x300C, 0x3010 in order.
3. Wrap: run 10 cycles of continuous push+pop at count=2. count stays 2, and the output order matches input order across the pointer wrap.
4. Flush with push: hold count=3, then flush=1 with a push of add4 0x3020. Next cycle: count=1 and out_add4=0x3020. The dropped entries never appear at the output.
5. Reset mid-operation: with count=3, assert reset for one cycle. Then count=0, out_valid=0, out_instr=0 and in_ready=1.
6. Bypass, with FETCH_QUEUE_BYPASS_EN defined: empty queue, push 32'h2402_0005 with out_ready=1. Same cycle: out_valid=1 and out_instr=32'h2402_0005; next cycle count=0. Without the macro: same-cycle out_valid=0, and the next cycle count=1.
